// File: rtl/gwct_packet_burst_pkg.sv
// Shared constants, state encodings and command decode helpers for the GWCT
// packet/burst framing layer.
package gwct_packet_burst_pkg;

  localparam logic [7:0] MagicByte    = 8'h47;
  localparam logic [7:0] CmdRdInc     = 8'h01;
  localparam logic [7:0] CmdWrInc     = 8'h02;
  localparam logic [7:0] CmdRdFix     = 8'h11;
  localparam logic [7:0] CmdWrFix     = 8'h12;
  localparam logic [7:0] StatusOk     = 8'h00;
  localparam logic [7:0] StatusApbErr = 8'h01;
  localparam logic [7:0] StatusBadChk = 8'h02;
  localparam logic [7:0] ErrEcho      = 8'hFF;

  typedef enum logic [2:0] {
    StMagic, StCmd, StLen, StAddr, StData, StChk, StExec, StResp
  } rx_state_e;

  typedef enum logic [1:0] {TxIdle, TxHdr, TxData, TxChk} tx_phase_e;

  function automatic logic cmd_is_valid(logic [7:0] c);
    return (c == CmdRdInc) || (c == CmdWrInc) || (c == CmdRdFix) || (c == CmdWrFix);
  endfunction

  function automatic logic cmd_is_write(logic [7:0] c);
    return (c == CmdWrInc) || (c == CmdWrFix);
  endfunction

  function automatic logic cmd_is_fixed(logic [7:0] c);
    return (c == CmdRdFix) || (c == CmdWrFix);
  endfunction

endpackage

// File: rtl/gwct_packet_burst_if.sv
// Byte link + command bus bundle for the GWCT packet/burst block.
//   rx_data/rx_valid         : UART receive byte strobe (into the framer)
//   tx_data/tx_valid/tx_ready: UART transmit byte handshake (out of the framer)
//   cmd_*                    : beat request/completion to the APB master
// master = framer side, slave = UART/APB environment side.
interface gwct_packet_burst_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_write;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_rdata;
  logic              cmd_error;

  modport master (
    input  rx_data, rx_valid, tx_ready, cmd_ready, cmd_rdata, cmd_error,
    output tx_data, tx_valid, cmd_addr, cmd_wdata, cmd_write, cmd_valid
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, cmd_ready, cmd_rdata, cmd_error,
    input  tx_data, tx_valid, cmd_addr, cmd_wdata, cmd_write, cmd_valid
  );
endinterface

// File: rtl/gwct_packet_burst_tx_ser.sv
// Response serialiser: MAGIC, CMD echo, STATUS, LEN, optional LEN data words
// (little-endian, fetched through a word read port), then XOR checksum.
// Ports: i_clk/i_rst; i_start loads i_cmd/i_status/i_len/i_has_data;
//   o_raddr/i_rdata word buffer read port; o_tx_data/o_tx_valid/i_tx_ready byte
//   handshake; o_done pulses when the checksum byte is accepted.
module gwct_packet_burst_tx_ser
  import gwct_packet_burst_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned IDX_W      = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [7:0]              i_cmd,
  input  logic [7:0]              i_status,
  input  logic [7:0]              i_len,
  input  logic                    i_has_data,
  output logic [IDX_W-1:0]        o_raddr,
  input  logic [8*DATA_BYTES-1:0] i_rdata,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_done
);

  tx_phase_e  r_phase, w_phase_next;
  logic [7:0] r_cmd, r_status, r_len, r_chk, r_widx;
  logic [1:0] r_hidx, r_bidx;
  logic       r_has_data;
  logic       w_accept, w_last_byte;

  assign w_accept    = o_tx_valid && i_tx_ready;
  assign w_last_byte = (r_bidx == 2'(DATA_BYTES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_phase <= TxIdle;
    else       r_phase <= w_phase_next;
  end

  always_comb begin
    w_phase_next = r_phase;
    unique case (r_phase)
      TxIdle: if (i_start) w_phase_next = TxHdr;
      TxHdr:  if (w_accept && r_hidx == 2'd3) begin
                w_phase_next = (r_has_data && r_len != 8'd0) ? TxData : TxChk;
              end
      TxData: if (w_accept && w_last_byte && r_widx == r_len - 8'd1) w_phase_next = TxChk;
      TxChk:  if (w_accept) w_phase_next = TxIdle;
      default: w_phase_next = TxIdle;
    endcase
  end

  always_comb begin
    o_tx_valid = (r_phase != TxIdle);
    o_raddr    = r_widx[IDX_W-1:0];
    o_done     = (r_phase == TxChk) && i_tx_ready;
    o_tx_data  = 8'h00;
    unique case (r_phase)
      TxHdr: begin
        unique case (r_hidx)
          2'd0:    o_tx_data = MagicByte;
          2'd1:    o_tx_data = r_cmd;
          2'd2:    o_tx_data = r_status;
          default: o_tx_data = r_len;
        endcase
      end
      TxData:  o_tx_data = i_rdata[8*r_bidx +: 8];
      TxChk:   o_tx_data = r_chk;
      default: o_tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cmd      <= '0;
      r_status   <= '0;
      r_len      <= '0;
      r_chk      <= '0;
      r_widx     <= '0;
      r_hidx     <= '0;
      r_bidx     <= '0;
      r_has_data <= 1'b0;
    end else if (r_phase == TxIdle && i_start) begin
      r_cmd      <= i_cmd;
      r_status   <= i_status;
      r_len      <= i_len;
      r_has_data <= i_has_data;
      r_chk      <= '0;
      r_widx     <= '0;
      r_hidx     <= '0;
      r_bidx     <= '0;
    end else if (w_accept) begin
      r_chk <= r_chk ^ o_tx_data;
      if (r_phase == TxHdr) r_hidx <= r_hidx + 2'd1;
      if (r_phase == TxData) begin
        r_bidx <= w_last_byte ? 2'd0 : r_bidx + 2'd1;
        if (w_last_byte) r_widx <= r_widx + 8'd1;
      end
    end
  end

endmodule

// File: rtl/gwct_packet_burst.sv
// GWCT packet/burst framer: parses RX packets (MAGIC CMD LEN ADDR [DATA] CHK),
// runs the burst as sequential command beats and returns a status-coded
// response through the TX serialiser.
// Ports: i_clk, i_rst (sync, active high); bus (master side of the byte link
//   and command bus); o_busy high from checksum decision to last TX byte.
module gwct_packet_burst
  import gwct_packet_burst_pkg::*;
#(
  parameter int unsigned ADDR_BYTES = 4,
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned RX_TIMEOUT = 100000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  gwct_packet_burst_if.master bus,
  output logic                o_busy
);

  localparam int unsigned AddrW = 8 * ADDR_BYTES;
  localparam int unsigned DataW = 8 * DATA_BYTES;
  localparam int unsigned IdxW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int unsigned TmoW  = $clog2(RX_TIMEOUT + 1);

  rx_state_e        r_state, w_state_next;
  logic [7:0]       r_cmd, r_len, r_chk, r_beat;
  logic [1:0]       r_bcnt;
  logic [AddrW-1:0] r_addr;
  logic [TmoW-1:0]  r_tmo;
  logic             r_cmd_valid, r_pending, r_busy;
  logic [DataW-1:0] r_buf [MAX_BURST];

  logic             w_rx, w_in_pkt, w_tmo_hit, w_beat_done, w_last_beat, w_is_wr;
  logic             w_start, w_tx_done;
  logic [7:0]       w_st_status, w_st_len, w_tx_data;
  logic             w_tx_valid;
  logic [IdxW-1:0]  w_raddr;

  assign w_rx        = bus.rx_valid;
  assign w_is_wr     = cmd_is_write(r_cmd);
  assign w_in_pkt    = r_state inside {StCmd, StLen, StAddr, StData, StChk};
  assign w_tmo_hit   = w_in_pkt && !w_rx && (r_tmo == TmoW'(RX_TIMEOUT - 1));
  // cmd_ready outside an outstanding beat is ignored
  assign w_beat_done = (r_state == StExec) && r_pending && bus.cmd_ready;
  assign w_last_beat = (r_beat + 8'd1) == r_len;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StMagic;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StMagic: if (w_rx && bus.rx_data == MagicByte) w_state_next = StCmd;
      StCmd:   if (w_rx) w_state_next = cmd_is_valid(bus.rx_data) ? StLen : StMagic;
      StLen:   if (w_rx) begin
                 w_state_next = (bus.rx_data == 8'd0 || 32'(bus.rx_data) > MAX_BURST)
                                ? StMagic : StAddr;
               end
      StAddr:  if (w_rx && r_bcnt == 2'(ADDR_BYTES - 1)) w_state_next = w_is_wr ? StData : StChk;
      StData:  if (w_rx && r_bcnt == 2'(DATA_BYTES - 1) && r_beat == r_len - 8'd1) begin
                 w_state_next = StChk;
               end
      StChk:   if (w_rx) w_state_next = (bus.rx_data == r_chk) ? StExec : StResp;
      StExec:  if (w_beat_done && (bus.cmd_error || w_last_beat)) w_state_next = StResp;
      StResp:  if (w_tx_done) w_state_next = StMagic;
      default: w_state_next = StMagic;
    endcase
    if (w_tmo_hit) w_state_next = StMagic;
  end

  always_comb begin
    w_start     = 1'b0;
    w_st_status = StatusOk;
    w_st_len    = r_len;
    if (r_state == StChk && w_rx && bus.rx_data != r_chk) begin
      w_start     = 1'b1;
      w_st_status = StatusBadChk;
      w_st_len    = 8'd0;
    end else if (w_beat_done && bus.cmd_error) begin
      w_start     = 1'b1;
      w_st_status = StatusApbErr;
      w_st_len    = r_beat;
    end else if (w_beat_done && w_last_beat) begin
      w_start     = 1'b1;
    end
    bus.cmd_valid = r_cmd_valid;
    bus.cmd_write = (r_state == StExec) && w_is_wr;
    bus.cmd_addr  = (r_state == StExec) ? r_addr : '0;
    bus.cmd_wdata = ((r_state == StExec) && w_is_wr) ? r_buf[r_beat[IdxW-1:0]] : '0;
    bus.tx_data   = w_tx_data;
    bus.tx_valid  = w_tx_valid;
    o_busy        = r_busy;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cmd       <= '0;
      r_len       <= '0;
      r_chk       <= '0;
      r_beat      <= '0;
      r_bcnt      <= '0;
      r_addr      <= '0;
      r_tmo       <= '0;
      r_cmd_valid <= 1'b0;
      r_pending   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_tmo       <= (w_in_pkt && !w_rx) ? r_tmo + TmoW'(1) : '0;
      unique case (r_state)
        StMagic: begin
          r_chk  <= MagicByte;
          r_bcnt <= '0;
          r_beat <= '0;
        end
        StCmd: if (w_rx) begin
          r_cmd <= bus.rx_data;
          r_chk <= r_chk ^ bus.rx_data;
        end
        StLen: if (w_rx) begin
          r_len <= bus.rx_data;
          r_chk <= r_chk ^ bus.rx_data;
        end
        StAddr: if (w_rx) begin
          r_addr[8*r_bcnt +: 8] <= bus.rx_data;
          r_chk  <= r_chk ^ bus.rx_data;
          r_bcnt <= (r_bcnt == 2'(ADDR_BYTES - 1)) ? 2'd0 : r_bcnt + 2'd1;
        end
        StData: if (w_rx) begin
          r_chk  <= r_chk ^ bus.rx_data;
          r_bcnt <= (r_bcnt == 2'(DATA_BYTES - 1)) ? 2'd0 : r_bcnt + 2'd1;
          if (r_bcnt == 2'(DATA_BYTES - 1)) r_beat <= r_beat + 8'd1;
        end
        StChk: if (w_rx) begin
          r_beat <= '0;
          r_busy <= 1'b1;
          if (bus.rx_data == r_chk) begin
            r_cmd_valid <= 1'b1;
            r_pending   <= 1'b1;
          end
        end
        StExec: if (w_beat_done) begin
          r_pending <= 1'b0;
          if (!bus.cmd_error && !w_last_beat) begin
            r_beat      <= r_beat + 8'd1;
            r_cmd_valid <= 1'b1;
            r_pending   <= 1'b1;
            if (!cmd_is_fixed(r_cmd)) r_addr <= r_addr + AddrW'(DATA_BYTES);
          end
        end
        StResp: if (w_tx_done) r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  // Word buffer: write payload while receiving, read data while executing.
  always_ff @(posedge i_clk) begin
    if (r_state == StData && w_rx) r_buf[r_beat[IdxW-1:0]][8*r_bcnt +: 8] <= bus.rx_data;
    if (w_beat_done && !w_is_wr && !bus.cmd_error) r_buf[r_beat[IdxW-1:0]] <= bus.cmd_rdata;
  end

  gwct_packet_burst_tx_ser #(
    .DATA_BYTES (DATA_BYTES),
    .IDX_W      (IdxW)
  ) u_tx_ser (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (w_start),
    .i_cmd      ((w_st_status != StatusOk) ? ErrEcho : r_cmd),
    .i_status   (w_st_status),
    .i_len      (w_st_len),
    .i_has_data (!w_is_wr && (w_st_status == StatusOk)),
    .o_raddr    (w_raddr),
    .i_rdata    (r_buf[w_raddr]),
    .o_tx_data  (w_tx_data),
    .o_tx_valid (w_tx_valid),
    .i_tx_ready (bus.tx_ready),
    .o_done     (w_tx_done)
  );

endmodule

// File: tb/tb_gwct_packet_burst.sv
// Scoreboard bench for gwct_packet_burst: expected beats and response bytes are
// queued when a packet is built; a command responder and a TX monitor pop and
// compare as the DUT produces them.
module tb_gwct_packet_burst;

  localparam int unsigned AB = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned MB = 8;
  localparam int unsigned TO = 40;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  gwct_packet_burst_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  gwct_packet_burst #(
    .ADDR_BYTES (AB),
    .DATA_BYTES (DB),
    .MAX_BURST  (MB),
    .RX_TIMEOUT (TO)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus    (bus),
    .o_busy (busy)
  );

  beat_t       exp_cmd[$];
  rsp_t        rsp_q[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  pkt[$];
  logic [31:0] wr_words[$];
  logic [31:0] rd_words[$];
  int n_checks = 0;
  int n_fail = 0;
  int stall_left = 0;
  int stall_at = -1;
  int tx_acc = 0;

  // Command responder: completes each beat one cycle after cmd_valid.
  initial begin : responder
    beat_t e;
    rsp_t  r;
    bus.cmd_ready = 1'b0;
    bus.cmd_error = 1'b0;
    bus.cmd_rdata = '0;
    forever begin
      @(negedge clk);
      bus.cmd_ready = 1'b0;
      bus.cmd_error = 1'b0;
      bus.cmd_rdata = '0;
      if (!rst && bus.cmd_valid === 1'b1) begin
        n_checks++;
        if (exp_cmd.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got addr=%h write=%b, required no beat",
                   bus.cmd_addr, bus.cmd_write);
        end else begin
          e = exp_cmd.pop_front();
          if (bus.cmd_addr !== e.addr || bus.cmd_write !== e.write ||
              (e.write && bus.cmd_wdata !== e.wdata)) begin
            n_fail++;
            $display("FAIL beat: got addr=%h write=%b wdata=%h, required addr=%h write=%b wdata=%h",
                     bus.cmd_addr, bus.cmd_write, bus.cmd_wdata, e.addr, e.write, e.wdata);
          end
        end
        @(negedge clk);
        bus.cmd_ready = 1'b1;
        if (rsp_q.size() > 0) begin
          r = rsp_q.pop_front();
          bus.cmd_rdata = r.rdata;
          bus.cmd_error = r.err;
        end
      end
    end
  end

  // TX monitor: drives tx_ready, checks accepted bytes and hold stability.
  initial begin : tx_monitor
    logic       prev_pend;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_pend    = 1'b0;
    prev_data    = '0;
    bus.tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_pend    = 1'b0;
        bus.tx_ready = 1'b0;
      end else begin
        if (prev_pend) begin
          n_checks++;
          if (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data) begin
            n_fail++;
            $display("FAIL tx_hold: got valid=%b data=%h, required valid=1 data=%h",
                     bus.tx_valid, bus.tx_data, prev_data);
          end
        end
        if (bus.tx_valid === 1'b1 && stall_left > 0 && tx_acc == stall_at) begin
          bus.tx_ready = 1'b0;
          stall_left--;
        end else begin
          bus.tx_ready = 1'b1;
        end
        if (bus.tx_valid === 1'b1 && bus.tx_ready) begin
          n_checks++;
          if (exp_tx.size() == 0) begin
            n_fail++;
            $display("FAIL tx_byte: got %h, required no byte", bus.tx_data);
          end else begin
            e = exp_tx.pop_front();
            if (bus.tx_data !== e) begin
              n_fail++;
              $display("FAIL tx_byte %0d: got %h, required %h", tx_acc, bus.tx_data, e);
            end
          end
          tx_acc++;
        end
        prev_pend = (bus.tx_valid === 1'b1) && !bus.tx_ready;
        prev_data = bus.tx_data;
      end
    end
  end

  task automatic build_pkt(input logic [7:0] cmd, input logic [7:0] len,
                           input logic [31:0] addr, input bit corrupt);
    logic [7:0]  chk;
    logic [31:0] w;
    pkt.delete();
    pkt.push_back(8'h47);
    pkt.push_back(cmd);
    pkt.push_back(len);
    for (int i = 0; i < 4; i++) pkt.push_back(addr[8*i +: 8]);
    if (cmd == 8'h02 || cmd == 8'h12) begin
      for (int i = 0; i < wr_words.size(); i++) begin
        w = wr_words[i];
        for (int b = 0; b < 4; b++) pkt.push_back(w[8*b +: 8]);
      end
    end
    chk = 8'h00;
    for (int i = 0; i < pkt.size(); i++) chk ^= pkt[i];
    if (corrupt) chk ^= 8'h5A;
    pkt.push_back(chk);
  endtask

  task automatic drive_pkt();
    for (int i = 0; i < pkt.size(); i++) begin
      @(negedge clk);
      bus.rx_data  = pkt[i];
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
  endtask

  task automatic expect_beats(input logic [7:0] cmd, input logic [31:0] addr, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.addr  = cmd[4] ? addr : addr + 32'(4 * i);
      b.write = cmd[1];
      b.wdata = cmd[1] ? wr_words[i] : 32'h0;
      exp_cmd.push_back(b);
    end
  endtask

  task automatic expect_resp(input logic [7:0] cmd, input logic [7:0] status,
                             input logic [7:0] len);
    logic [7:0]  hdr[4];
    logic [7:0]  chk;
    logic [31:0] w;
    hdr[0] = 8'h47;
    hdr[1] = (status != 8'h00) ? 8'hFF : cmd;
    hdr[2] = status;
    hdr[3] = len;
    chk = 8'h00;
    for (int i = 0; i < 4; i++) begin
      exp_tx.push_back(hdr[i]);
      chk ^= hdr[i];
    end
    if (status == 8'h00 && !cmd[1]) begin
      for (int i = 0; i < int'(len); i++) begin
        w = rd_words[i];
        for (int b = 0; b < 4; b++) begin
          exp_tx.push_back(w[8*b +: 8]);
          chk ^= w[8*b +: 8];
        end
      end
    end
    exp_tx.push_back(chk);
  endtask

  task automatic push_rsp(input logic [31:0] d, input logic err);
    rsp_t r;
    r.rdata = d;
    r.err   = err;
    rsp_q.push_back(r);
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    while (cyc < 3000 && (exp_tx.size() != 0 || exp_cmd.size() != 0 || busy !== 1'b0)) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc >= 3000) begin
      n_fail++;
      $display("FAIL %s: idle wait expired, pending tx=%0d beats=%0d busy=%b, required 0/0/0",
               name, exp_tx.size(), exp_cmd.size(), busy);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.tx_valid, bus.cmd_valid, bus.cmd_write, busy} !== 4'b0 ||
        bus.tx_data !== 8'h00 || bus.cmd_addr !== 32'h0 || bus.cmd_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: got tx_valid=%b cmd_valid=%b busy=%b addr=%h, required all 0",
               bus.tx_valid, bus.cmd_valid, busy, bus.cmd_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    logic [7:0] lit[9] = '{8'h47, 8'h01, 8'h00, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h65};
    exp_cmd.push_back('{addr: 32'h0000_1000, wdata: 32'h0, write: 1'b0});
    push_rsp(32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 9; i++) exp_tx.push_back(lit[i]);
    build_pkt(8'h01, 8'd1, 32'h0000_1000, 1'b0);
    n_checks++;
    if (pkt[7] !== 8'h57) begin
      n_fail++;
      $display("FAIL single_read_pkt: got chk %h, required 57", pkt[7]);
    end
    drive_pkt();
    wait_idle("single_read");
  endtask

  task automatic test_burst_write();
    wr_words = '{32'h1, 32'h2, 32'h3};
    expect_beats(8'h02, 32'h2000, 3);
    for (int i = 0; i < 3; i++) push_rsp(32'h0, 1'b0);
    expect_resp(8'h02, 8'h00, 8'd3);
    build_pkt(8'h02, 8'd3, 32'h2000, 1'b0);
    drive_pkt();
    wait_idle("burst_write");
  endtask

  task automatic test_fixed_read();
    rd_words = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    expect_beats(8'h11, 32'h30, 4);
    for (int i = 0; i < 4; i++) push_rsp(rd_words[i], 1'b0);
    expect_resp(8'h11, 8'h00, 8'd4);
    build_pkt(8'h11, 8'd4, 32'h30, 1'b0);
    drive_pkt();
    wait_idle("fixed_read");
  endtask

  task automatic test_apb_error();
    logic [7:0] lit[5] = '{8'h47, 8'hFF, 8'h01, 8'h01, 8'hB8};
    expect_beats(8'h01, 32'h100, 2);
    push_rsp(32'hA5A5_0001, 1'b0);
    push_rsp(32'h0, 1'b1);
    for (int i = 0; i < 5; i++) exp_tx.push_back(lit[i]);
    build_pkt(8'h01, 8'd4, 32'h100, 1'b0);
    drive_pkt();
    wait_idle("apb_error");
    n_checks++;
    if (rsp_q.size() != 0) begin
      n_fail++;
      $display("FAIL apb_error_beats: got %0d unconsumed responses, required 0", rsp_q.size());
    end
  endtask

  task automatic test_bad_chk();
    logic [7:0] lit[5] = '{8'h47, 8'hFF, 8'h02, 8'h00, 8'hBA};
    wr_words = '{32'hCAFE_F00D};
    for (int i = 0; i < 5; i++) exp_tx.push_back(lit[i]);
    build_pkt(8'h02, 8'd1, 32'h40, 1'b1);
    drive_pkt();
    wait_idle("bad_chk");
  endtask

  task automatic test_bad_header();
    build_pkt(8'h05, 8'd1, 32'h0, 1'b0);
    drive_pkt();
    build_pkt(8'h01, 8'd0, 32'h0, 1'b0);
    drive_pkt();
    build_pkt(8'h01, 8'(MB + 1), 32'h0, 1'b0);
    drive_pkt();
    wait_idle("bad_header");
    rd_words = '{32'h0BAD_0001};
    expect_beats(8'h01, 32'h80, 1);
    push_rsp(rd_words[0], 1'b0);
    expect_resp(8'h01, 8'h00, 8'd1);
    build_pkt(8'h01, 8'd1, 32'h80, 1'b0);
    drive_pkt();
    wait_idle("after_bad_header");
  endtask

  task automatic test_timeout();
    build_pkt(8'h01, 8'd1, 32'h0000_1000, 1'b0);
    pkt = pkt[0:4];
    drive_pkt();
    repeat (TO + 10) @(negedge clk);
    rd_words = '{32'h7777_8888};
    expect_beats(8'h01, 32'h44, 1);
    push_rsp(rd_words[0], 1'b0);
    expect_resp(8'h01, 8'h00, 8'd1);
    build_pkt(8'h01, 8'd1, 32'h44, 1'b0);
    drive_pkt();
    wait_idle("timeout");
  endtask

  task automatic test_tx_stall();
    rd_words = '{32'h0102_0304, 32'h0506_0708};
    expect_beats(8'h01, 32'h200, 2);
    for (int i = 0; i < 2; i++) push_rsp(rd_words[i], 1'b0);
    expect_resp(8'h01, 8'h00, 8'd2);
    stall_at   = tx_acc + 4;
    stall_left = 50;
    build_pkt(8'h01, 8'd2, 32'h200, 1'b0);
    drive_pkt();
    wait_idle("tx_stall");
    n_checks++;
    if (stall_left != 0) begin
      n_fail++;
      $display("FAIL tx_stall_applied: got %0d stall cycles left, required 0", stall_left);
    end
  endtask

  task automatic test_rst_mid_exec();
    int cyc = 0;
    expect_beats(8'h01, 32'h400, 4);
    for (int i = 0; i < 4; i++) push_rsp(32'h9000_0000 + 32'(i), 1'b0);
    build_pkt(8'h01, 8'd4, 32'h400, 1'b0);
    drive_pkt();
    while (bus.cmd_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc >= 100) begin
      n_fail++;
      $display("FAIL rst_exec_start: got no cmd_valid, required a beat");
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.tx_valid, bus.cmd_valid, bus.cmd_write, busy} !== 4'b0 ||
        bus.tx_data !== 8'h00 || bus.cmd_addr !== 32'h0 || bus.cmd_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_exec: got tx_valid=%b cmd_valid=%b busy=%b addr=%h, required all 0",
               bus.tx_valid, bus.cmd_valid, busy, bus.cmd_addr);
    end
    rst = 1'b0;
    exp_cmd.delete();
    rsp_q.delete();
    exp_tx.delete();
    repeat (3) @(negedge clk);
    wr_words = '{32'h1234_5678};
    expect_beats(8'h02, 32'h500, 1);
    push_rsp(32'h0, 1'b0);
    expect_resp(8'h02, 8'h00, 8'd1);
    build_pkt(8'h02, 8'd1, 32'h500, 1'b0);
    drive_pkt();
    wait_idle("after_rst");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_write();
    test_fixed_read();
    test_apb_error();
    test_bad_chk();
    test_bad_header();
    test_timeout();
    test_tx_stall();
    test_rst_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gwct_packet_burst.md
Name: gwct_packet_burst

Overview:
Parametrised next-generation framing layer for the GWCT debug protocol. It sits between the UART byte link and the APB master command interface. It adds configurable address/data widths, multi-beat burst read/write with incrementing or fixed address, an inter-byte RX timeout, and status-coded responses. Write data is buffered until the packet checksum passes, and read data is buffered until the burst completes.

Parameters:
ADDR_BYTES, 4, address field bytes (1..4); ADDR_W = 8*ADDR_BYTES
DATA_BYTES, 4, data word bytes (1..4); DATA_W = 8*DATA_BYTES
MAX_BURST, 8, maximum beats per packet (1..255); sizes the shared word buffer
RX_TIMEOUT, 100000, clk cycles of RX idle mid-packet before resync

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to UART TX
tx_valid  out  1  byte offered; held until accepted
tx_ready  in  1  UART accepts byte when tx_valid && tx_ready at posedge
cmd_addr  out  ADDR_W  beat address
cmd_wdata  out  DATA_W  beat write data
cmd_write  out  1  1=write beat
cmd_valid  out  1  one-cycle beat request
cmd_ready  in  1  one-cycle beat completion
cmd_rdata  in  DATA_W  read data, valid with cmd_ready
cmd_error  in  1  beat error, valid with cmd_ready
busy  out  1  high from checksum accept until last response byte accepted

Behaviour:
- Reset (rst high at posedge): all outputs 0; FSM to RX_MAGIC; buffer contents don't-care.
- RX packet, in order: 0x47; CMD; LEN; ADDR (LE, ADDR_BYTES); write only: LEN*DATA_BYTES data bytes (LE per word); CHK = XOR of all prior bytes.
- CMD: 0x01 read incr, 0x02 write incr, 0x11 read fixed, 0x12 write fixed. Any other value -> RX_MAGIC, no response.
- LEN = 0 or > MAX_BURST -> RX_MAGIC, no response.
- RX states: MAGIC, CMD, LEN, ADDR, DATA, CHK, EXEC, RESP. Non-0x47 bytes in MAGIC are discarded.
- Timeout: counter clears on each rx_valid. It counts only in CMD..CHK. At RX_TIMEOUT, go to MAGIC and discard the partial packet.
- Bad CHK -> send a NAK response (STATUS=0x02, LEN=0), with no APB activity.
- EXEC: issue beats sequentially. cmd_valid pulses 1 cycle after the previous cmd_ready (first beat 1 cycle after CHK accepted). cmd_addr = base + i*DATA_BYTES (incr, wraps mod 2^ADDR_W) or base (fixed).
- Read beat: cmd_rdata is stored into buf[i] on cmd_ready.
- On cmd_error: stop issuing beats; STATUS=0x01; response LEN = beats completed before the erroring beat.
- TX response: 0x47; CMD echo (0xFF if STATUS!=0); STATUS; LEN; for read with STATUS=0, LEN words LE; CHK = XOR of prior bytes. Write ack carries no data.
- TX handshake: tx_valid stays high with tx_data stable until tx_ready is sampled high. The next byte may be offered the following cycle. tx_valid is never dropped without acceptance.
- rx_valid during EXEC/RESP: byte dropped. The RX FSM re-enters MAGIC the cycle after the final CHK byte is accepted.
- cmd_ready with no outstanding beat: ignored.
- Minimum latency: one beat completes 2 cycles after cmd_valid; the first response byte is offered the cycle after the last cmd_ready.

Decomposition:
- Shared header gwct_pkt_defs.vh: MAGIC 0x47, CMD codes, STATUS codes (OK 0x00, APB_ERR 0x01, BAD_CHK 0x02), error echo 0xFF.
- One sub-module, gwct_pkt_tx_ser: takes header fields, LEN, and a word-buffer read port, and serialises bytes with running XOR and the valid/ready handshake.

Test Plan:
- Single read (ADDR_BYTES=DATA_BYTES=4): rx 47 01 01 00 10 00 00 57, cmd_rdata=DEADBEEF -> cmd_addr=00001000, write=0; tx 47 01 00 01 EF BE AD DE 65.
- Burst write incr LEN=3 @0x2000 with words 1,2,3 -> three cmd_valid at 2000/2004/2008, wdata 1/2/3; tx 47 02 00 03 then correct CHK.
- Fixed-address read LEN=4 @0x30 -> all four beats at addr 0x30; four distinct rdata returned in order.
- Error on beat 2 of LEN=4 read -> beats 3-4 not issued; tx 47 FF 01 01 CHK.
- Corrupt CHK byte -> no cmd_valid; tx 47 FF 02 00 BA. Separately, stall mid-ADDR > RX_TIMEOUT then a valid packet -> only the second packet executes.
- tx_ready held low 50 cycles mid-response -> tx_data/tx_valid stable throughout; rst asserted mid-EXEC -> all outputs 0 next cycle and the next packet is accepted.
